// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the fetch stage: PC stride and the F->D message layout.
package fetch_unit_pkg;

  localparam int FETCH_INCR    = 4;
  localparam int F2D_INST_BITS = 32;
  localparam int F2D_ADDR_BITS = 32;

  typedef struct packed {
    logic [F2D_INST_BITS-1:0] inst;
    logic [F2D_ADDR_BITS-1:0] pc;
  } f2d_msg_t;

endpackage

// File: rtl/fetch_unit_pc_queue.sv
// FIFO of issued fetch addresses; head is the PC of the oldest outstanding response.
module fetch_unit_pc_queue #(
  parameter int p_depth = 4,
  parameter int p_width = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_push,
  input  logic               i_pop,
  input  logic [p_width-1:0] i_data,
  output logic [p_width-1:0] o_head,
  output logic               o_empty,
  output logic               o_full
);

  localparam int PTR_W = (p_depth > 1) ? $clog2(p_depth) : 1;
  localparam int CNT_W = $clog2(p_depth + 1);
  localparam logic [PTR_W-1:0] LAST  = PTR_W'(p_depth - 1);
  localparam logic [CNT_W-1:0] DEPTH = CNT_W'(p_depth);

  logic [p_width-1:0] r_mem [p_depth];
  logic [PTR_W-1:0]   r_wr;
  logic [PTR_W-1:0]   r_rd;
  logic [CNT_W-1:0]   r_cnt;
  logic               w_do_push;
  logic               w_do_pop;

  function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
    return (p == LAST) ? '0 : p + PTR_W'(1);
  endfunction

  // A push into a full queue is allowed when the head leaves in the same cycle.
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_do_push) r_wr <= bump(r_wr);
      if (w_do_pop)  r_rd <= bump(r_rd);
      r_cnt <= r_cnt + CNT_W'(w_do_push) - CNT_W'(w_do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr] <= i_data;
  end

  assign o_head  = r_mem[r_rd];
  assign o_empty = (r_cnt == '0);
  assign o_full  = (r_cnt == DEPTH);

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: sequential requests from pc_reg, response/PC pairing,
// and squash-driven redirect that discards all stale in-flight responses.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int                   p_addr_bits     = 32,
  parameter int                   p_inst_bits     = 32,
  parameter logic [p_addr_bits-1:0] p_rst_addr    = p_addr_bits'(32'h200),
  parameter int                   p_max_in_flight = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic                   mem_req_val,
  input  logic                   mem_req_rdy,
  output logic [p_addr_bits-1:0] mem_req_addr,
  input  logic                   mem_resp_val,
  output logic                   mem_resp_rdy,
  input  logic [p_inst_bits-1:0] mem_resp_data,
  output logic                   D_val,
  input  logic                   D_rdy,
  output logic [p_inst_bits-1:0] D_inst,
  output logic [p_addr_bits-1:0] D_pc,
  input  logic                   D_squash,
  input  logic [p_addr_bits-1:0] D_branch_target
);

  localparam int CNT_W = $clog2(p_max_in_flight + 1);
  localparam logic [CNT_W-1:0]       MAX_CNT = CNT_W'(p_max_in_flight);
  localparam logic [p_addr_bits-1:0] PC_INCR = p_addr_bits'(FETCH_INCR);

  logic [p_addr_bits-1:0] r_pc;
  logic [CNT_W-1:0]       r_in_flight;
  logic [CNT_W-1:0]       r_drop;

  logic [p_addr_bits-1:0] w_head;
  logic                   w_q_empty;
  logic                   w_q_full;
  logic                   w_dropping;
  logic                   w_req_fire;
  logic                   w_resp_fire;

  // Every channel (mem_req, mem_resp, D) transfers on a rising edge where val and rdy
  // are both high; val never waits on rdy, and a valid payload holds until it transfers.
  assign w_dropping   = (r_drop != '0);
  assign mem_req_val  = !rst && (r_in_flight < MAX_CNT) && !w_q_full && !D_squash;
  assign mem_req_addr = r_pc;
  assign mem_resp_rdy = !rst && (w_dropping || D_rdy);
  assign D_val        = !rst && !w_dropping && mem_resp_val && !w_q_empty;
  assign D_inst       = mem_resp_data;
  assign D_pc         = w_head;

  assign w_req_fire  = mem_req_val && mem_req_rdy;
  assign w_resp_fire = mem_resp_val && mem_resp_rdy;

  fetch_unit_pc_queue #(
    .p_depth (p_max_in_flight),
    .p_width (p_addr_bits)
  ) u_pc_queue (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_req_fire),
    .i_pop   (w_resp_fire),
    .i_data  (r_pc),
    .o_head  (w_head),
    .o_empty (w_q_empty),
    .o_full  (w_q_full)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc        <= p_rst_addr;
      r_in_flight <= '0;
      r_drop      <= '0;
    end else begin
      if (D_squash)        r_pc <= {D_branch_target[p_addr_bits-1:2], 2'b00};
      else if (w_req_fire) r_pc <= r_pc + PC_INCR;

      r_in_flight <= r_in_flight + CNT_W'(w_req_fire) - CNT_W'(w_resp_fire);

      // Squash blocks issue, so everything in flight (minus one retiring now) is stale.
      if (D_squash)                       r_drop <= r_in_flight - CNT_W'(w_resp_fire);
      else if (w_resp_fire && w_dropping) r_drop <= r_drop - CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: in-order memory model, expected-delivery scoreboard, directed and random steps.
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  localparam int MAXF = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_req_val;
  logic        mem_req_rdy;
  logic [31:0] mem_req_addr;
  logic        mem_resp_val;
  logic        mem_resp_rdy;
  logic [31:0] mem_resp_data;
  logic        D_val;
  logic        D_rdy;
  logic [31:0] D_inst;
  logic [31:0] D_pc;
  logic        D_squash;
  logic [31:0] D_branch_target;

  fetch_unit #(
    .p_addr_bits     (32),
    .p_inst_bits     (32),
    .p_rst_addr      (32'h200),
    .p_max_in_flight (MAXF)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .mem_req_val     (mem_req_val),
    .mem_req_rdy     (mem_req_rdy),
    .mem_req_addr    (mem_req_addr),
    .mem_resp_val    (mem_resp_val),
    .mem_resp_rdy    (mem_resp_rdy),
    .mem_resp_data   (mem_resp_data),
    .D_val           (D_val),
    .D_rdy           (D_rdy),
    .D_inst          (D_inst),
    .D_pc            (D_pc),
    .D_squash        (D_squash),
    .D_branch_target (D_branch_target)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  // model state
  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          lat_lo = 0;
  int          lat_hi = 0;
  logic [31:0] mq_addr[$];     // outstanding memory requests, oldest first
  int          mq_rdy[$];      // cycle from which each response may be presented
  logic [63:0] exp_q[$];       // deliveries decode still expects, as f2d_msg_t
  logic [31:0] exp_req_addr;
  bit          chk_next = 0;
  logic [31:0] want_pc;

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'hDEAD_BEEF;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  function automatic void model_reset();
    mq_addr.delete();
    mq_rdy.delete();
    exp_q.delete();
    exp_req_addr = 32'h200;
  endfunction

  // driver: one clock cycle of stimulus, checks, and model update
  task automatic step(input bit d_rdy_i, input bit sq_i, input logic [31:0] tgt_i, input bit req_rdy_i);
    bit       head_ok, stale, exp_req_val, exp_rr, req_fire, resp_fire, d_fire;
    f2d_msg_t m;
    @(negedge clk);
    D_rdy           = d_rdy_i;
    D_squash        = sq_i;
    D_branch_target = tgt_i;
    mem_req_rdy     = req_rdy_i;
    head_ok         = (mq_addr.size() > 0) && (mq_rdy[0] <= cyc);
    mem_resp_val    = head_ok;
    mem_resp_data   = head_ok ? inst_of(mq_addr[0]) : $urandom;
    #1;
    stale       = mq_addr.size() > exp_q.size();
    exp_req_val = (mq_addr.size() < MAXF) && !sq_i;
    exp_rr      = stale ? 1'b1 : d_rdy_i;
    chk("req_val", mem_req_val, exp_req_val);
    if (exp_req_val) chk("req_addr", mem_req_addr, exp_req_addr);
    chk("resp_rdy", mem_resp_rdy, exp_rr);
    chk("d_val", D_val, head_ok && !stale);
    if (head_ok && !stale) chk("d_msg", {D_inst, D_pc}, exp_q[0]);

    req_fire  = exp_req_val && req_rdy_i;
    resp_fire = head_ok && exp_rr;
    d_fire    = head_ok && !stale && d_rdy_i;
    if (d_fire && chk_next) begin
      chk("first_pc", D_pc, want_pc);
      chk_next = 0;
    end
    if (d_fire) void'(exp_q.pop_front());
    if (resp_fire) begin
      void'(mq_addr.pop_front());
      void'(mq_rdy.pop_front());
    end
    if (sq_i) begin
      exp_q.delete();
      exp_req_addr = tgt_i;
    end
    if (req_fire) begin
      mq_addr.push_back(exp_req_addr);
      mq_rdy.push_back(cyc + 1 + $urandom_range(lat_hi, lat_lo));
      m.inst = inst_of(exp_req_addr);
      m.pc   = exp_req_addr;
      exp_q.push_back(m);
      exp_req_addr = exp_req_addr + 32'd4;
    end
    cyc++;
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && mq_addr.size() != 0; i++) step(1, 0, 0, 0);
  endtask

  task automatic squash_to(input bit d_rdy_i, input logic [31:0] tgt);
    step(d_rdy_i, 1, tgt, 1);
    chk_next = 1;
    want_pc  = tgt;
  endtask

  task automatic run(input int n, input bit d_rdy_i);
    for (int i = 0; i < n; i++) step(d_rdy_i, 0, 0, 1);
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_req_val"}, mem_req_val, 1'b0);
    chk({tag, "_resp_rdy"}, mem_resp_rdy, 1'b0);
    chk({tag, "_d_val"}, D_val, 1'b0);
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_exit_req_val", mem_req_val, 1'b1);
    chk("rst_exit_req_addr", mem_req_addr, 32'h200);
    model_reset();
    chk_next = 1;
    want_pc  = 32'h200;
  endtask

  // directed sequence
  initial begin
    rst = 1'b1; D_rdy = 1'b1; D_squash = 1'b0; D_branch_target = '0;
    mem_req_rdy = 1'b0; mem_resp_val = 1'b0; mem_resp_data = '0;
    model_reset();
    #12;
    reset_checks("rst");
    repeat (2) @(posedge clk);
    release_reset();

    // zero-latency memory, full throughput
    lat_lo = 0; lat_hi = 0;
    run(12, 1);

    // 3-cycle latency: fifth request must stall until the first response retires
    drain();
    lat_lo = 3; lat_hi = 3;
    run(20, 1);

    // decode back-pressure mid-stream
    lat_lo = 1; lat_hi = 1;
    run(4, 1);
    run(5, 0);
    run(8, 1);

    // squash with three requests in flight and no same-cycle transfer
    drain();
    lat_lo = 5; lat_hi = 5;
    run(3, 1);
    squash_to(1, 32'h400);
    run(25, 1);

    // squash together with a transfer, then a second squash while dropping
    drain();
    lat_lo = 2; lat_hi = 2;
    run(3, 1);
    squash_to(1, 32'h800);
    squash_to(1, 32'hC00);
    run(20, 1);

    // PC wraps modulo 2^32
    lat_lo = 0; lat_hi = 1;
    squash_to(1, 32'hFFFF_FFFC);
    run(15, 1);

    // randomized traffic
    lat_lo = 0; lat_hi = 4;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(15, 0) == 0) begin
        squash_to($urandom_range(1, 0) == 1, $urandom & 32'hFFFF_FFFC);
      end else begin
        step($urandom_range(3, 0) != 0, 0, 0, $urandom_range(3, 0) != 0);
      end
    end

    // asynchronous reset with two requests in flight
    drain();
    lat_lo = 3; lat_hi = 3;
    run(2, 1);
    #2;
    rst = 1'b1;
    mem_resp_val = 1'b0;
    mem_req_rdy  = 1'b0;
    #1;
    reset_checks("mid_rst");
    @(posedge clk);
    #1;
    reset_checks("mid_rst_hold");
    release_reset();
    lat_lo = 0; lat_hi = 2;
    run(15, 1);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
